// File: rtl/intr_pkg.sv
// Shared encodings and reset values for the interrupt arbiter slice.
// Pure declarations: no latency, no flow control.
package intr_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HOLD = 2'b01,
        S_DROP = 2'b10,
        S_ACK  = 2'b11
    } state_t;

    localparam state_t RST_STATE    = S_IDLE;
    localparam logic   RST_EQL      = 1'b0;
    localparam logic   RST_CONT_EQL = 1'b1;
    localparam logic   RST_TIMEOUT  = 1'b0;

endpackage

// File: rtl/intr_arbiter_rr_pick.sv
// Round-robin select: first set req bit at or after ptr, wrapping modulo NREQ.
// Purely combinational (zero latency); valid low when no request is pending.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] gid,
    output logic             valid
);

    // Scan from the farthest offset down so the nearest request overwrites.
    always_comb begin
        gid   = '0;
        valid = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                gid = PTR_W'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/intr_arbiter.sv
// Round-robin front end sharing one interrupt handler between NREQ requesters.
// Service is hold_len+3 cycles minimum; new requests wait until the handler is idle again.
module intr_arbiter
    import intr_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [CNT_W-1:0] hold_len,
    input  logic             ackout,
    input  logic             enable_count,
    output logic             eql,
    output logic             cont_eql,
    output logic [NREQ-1:0]  grant,
    output logic [NREQ-1:0]  ack,
    output logic             timeout,
    output logic [CNT_W-1:0] busy_cnt
);

    localparam int               PTR_W   = (NREQ > 2) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state, state_n;
    logic             eql_n, cont_eql_n, timeout_n;
    logic             tmo_hit, tmo_hit_n;
    logic [NREQ-1:0]  grant_n, ack_n;
    logic [CNT_W-1:0] busy_cnt_n;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_n, hold_last;
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_n, tmo_inc;
    logic [PTR_W-1:0] ptr, ptr_n, gid, gid_n, gid_inc;
    logic [PTR_W-1:0] pick_gid;
    logic             pick_vld;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .gid   (pick_gid),
        .valid (pick_vld)
    );

    // A zero hold length behaves as one cycle of eql.
    assign hold_last = (hold_len == '0) ? '0 : hold_len - CNT_W'(1);
    assign tmo_inc   = tmo_cnt + CNT_W'(1);
    assign gid_inc   = (int'(gid) == NREQ - 1) ? '0 : gid + PTR_W'(1);

    always_comb begin
        state_n    = state;
        eql_n      = eql;
        cont_eql_n = cont_eql;
        grant_n    = grant;
        ack_n      = '0;
        timeout_n  = 1'b0;
        ptr_n      = ptr;
        gid_n      = gid;
        hold_cnt_n = hold_cnt;
        tmo_cnt_n  = tmo_cnt;
        tmo_hit_n  = tmo_hit;

        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    gid_n      = pick_gid;
                    grant_n    = NREQ'(1) << pick_gid;
                    eql_n      = 1'b1;
                    hold_cnt_n = '0;
                    state_n    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt == hold_last) begin
                    eql_n      = 1'b0;
                    cont_eql_n = 1'b0;
                    tmo_cnt_n  = '0;
                    tmo_hit_n  = 1'b0;
                    state_n    = S_DROP;
                end else begin
                    hold_cnt_n = hold_cnt + CNT_W'(1);
                end
            end
            S_DROP: begin
                if (ackout) begin
                    cont_eql_n = 1'b1;
                    state_n    = S_ACK;
                end else begin
                    tmo_cnt_n = tmo_inc;
                    if (tmo_inc == CNT_MAX) begin
                        cont_eql_n = 1'b1;
                        timeout_n  = 1'b1;
                        tmo_hit_n  = 1'b1;
                        state_n    = S_ACK;
                    end
                end
            end
            S_ACK: begin
                // The pointer advances past the owner even when the handler timed out.
                if (!tmo_hit) begin
                    ack_n = grant;
                end
                grant_n = '0;
                ptr_n   = gid_inc;
                state_n = S_IDLE;
            end
            default: begin
                state_n    = RST_STATE;
                eql_n      = RST_EQL;
                cont_eql_n = RST_CONT_EQL;
                grant_n    = '0;
                ptr_n      = '0;
                gid_n      = '0;
                hold_cnt_n = '0;
                tmo_cnt_n  = '0;
                tmo_hit_n  = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy_cnt_n = busy_cnt;
        if (state == S_ACK) begin
            busy_cnt_n = '0;
        end else if (|grant && enable_count && busy_cnt != CNT_MAX) begin
            busy_cnt_n = busy_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= RST_STATE;
            eql      <= RST_EQL;
            cont_eql <= RST_CONT_EQL;
            grant    <= '0;
            ack      <= '0;
            timeout  <= RST_TIMEOUT;
            busy_cnt <= '0;
            ptr      <= '0;
            gid      <= '0;
            hold_cnt <= '0;
            tmo_cnt  <= '0;
            tmo_hit  <= 1'b0;
        end else begin
            state    <= state_n;
            eql      <= eql_n;
            cont_eql <= cont_eql_n;
            grant    <= grant_n;
            ack      <= ack_n;
            timeout  <= timeout_n;
            busy_cnt <= busy_cnt_n;
            ptr      <= ptr_n;
            gid      <= gid_n;
            hold_cnt <= hold_cnt_n;
            tmo_cnt  <= tmo_cnt_n;
            tmo_hit  <= tmo_hit_n;
        end
    end

endmodule

// File: tb/tb_intr_arbiter.sv
// Bench for intr_arbiter: directed scenarios plus random traffic against a service-level model.
module tb_intr_arbiter;

    localparam int NREQ = 4;
    localparam int CNT_W = 4;
    localparam int TMO_CYCLES = 15;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [NREQ-1:0]  req = '0;
    logic [CNT_W-1:0] hold_len = '0;
    logic             ackout = 1'b0;
    logic             enable_count = 1'b0;
    logic             eql, cont_eql, timeout;
    logic [NREQ-1:0]  grant, ack;
    logic [CNT_W-1:0] busy_cnt;

    int n_checks = 0;
    int n_errors = 0;

    intr_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .hold_len     (hold_len),
        .ackout       (ackout),
        .enable_count (enable_count),
        .eql          (eql),
        .cont_eql     (cont_eql),
        .grant        (grant),
        .ack          (ack),
        .timeout      (timeout),
        .busy_cnt     (busy_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Service-level model: who owns the handler, how long eql has been up,
    // how many cycles the handler has been kept waiting, and the next-in-line pointer.
    localparam int P_IDLE = 0, P_HOLD = 1, P_WAIT = 2, P_DONE = 3;
    int              m_phase = P_IDLE;
    int              m_owner = 0;
    int              m_ptr = 0;
    int              m_held = 0;
    int              m_waited = 0;
    bit              m_tmo_hit = 0;
    bit              model_live = 0;
    logic            e_eql = 0, e_cont = 1, e_tmo = 0;
    logic [NREQ-1:0] e_grant = '0, e_ack = '0;
    logic [3:0]      e_busy = '0;

    always @(posedge clock) begin
        int hl_eff;
        bit found;
        if (!reset) begin
            m_phase = P_IDLE; m_owner = 0; m_ptr = 0; m_held = 0; m_waited = 0; m_tmo_hit = 0;
            e_eql = 0; e_cont = 1; e_tmo = 0; e_grant = '0; e_ack = '0; e_busy = '0;
        end else begin
            e_ack = '0;
            e_tmo = 0;
            if (m_phase == P_DONE) e_busy = '0;
            else if (e_grant != 0 && enable_count && e_busy != 4'd15) e_busy = e_busy + 4'd1;
            hl_eff = (hold_len == 0) ? 1 : int'(hold_len);
            case (m_phase)
                P_IDLE: begin
                    found = 0;
                    for (int k = 0; k < NREQ; k++) begin
                        if (!found && req[(m_ptr + k) % NREQ]) begin
                            found = 1;
                            m_owner = (m_ptr + k) % NREQ;
                        end
                    end
                    if (found) begin
                        e_grant = '0;
                        e_grant[m_owner] = 1'b1;
                        e_eql = 1;
                        m_held = 0;
                        m_phase = P_HOLD;
                    end
                end
                P_HOLD: begin
                    if (m_held == hl_eff - 1) begin
                        e_eql = 0; e_cont = 0; m_waited = 0; m_tmo_hit = 0;
                        m_phase = P_WAIT;
                    end else begin
                        m_held = (m_held + 1) % 16;
                    end
                end
                P_WAIT: begin
                    if (ackout) begin
                        e_cont = 1;
                        m_phase = P_DONE;
                    end else begin
                        m_waited++;
                        if (m_waited == TMO_CYCLES) begin
                            e_cont = 1; e_tmo = 1; m_tmo_hit = 1;
                            m_phase = P_DONE;
                        end
                    end
                end
                default: begin
                    if (!m_tmo_hit) e_ack = e_grant;
                    e_grant = '0;
                    m_ptr = (m_owner + 1) % NREQ;
                    m_phase = P_IDLE;
                end
            endcase
        end
        model_live = 1;
    end

    always @(negedge clock) begin
        if (model_live) begin
            chk("outputs{eql,cont,grant,ack,tmo,busy}",
                32'({eql, cont_eql, grant, ack, timeout, busy_cnt}),
                32'({e_eql, e_cont, e_grant, e_ack, e_tmo, e_busy}));
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_grant_clear(input string name);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (grant == 0) begin ok = 1; break; end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    initial begin
        logic [NREQ-1:0] order [5];
        logic [NREQ-1:0] prev;
        int n_got, cnt, ack_pct;
        bit ok;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        // Reset held with every requester asking.
        req = 4'b1111; hold_len = 4'd1;
        repeat (3) tick();
        chk("rst_eql", 32'(eql), 32'd0);
        chk("rst_cont_eql", 32'(cont_eql), 32'd1);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack_tmo_busy", 32'({ack, timeout, busy_cnt}), 32'd0);
        reset = 1'b1;
        tick();
        chk("release_grant", 32'(grant), 32'b0001);
        req = '0; ackout = 1'b1;
        wait_grant_clear("first_service_done");
        ackout = 1'b0;

        // Single request, owner drops req mid-hold, ack two cycles after cont_eql falls.
        req = 4'b0100; hold_len = 4'd3;
        cnt = 0; ok = 0;
        tick();
        req = '0;
        for (int i = 0; i < 20; i++) begin
            if (eql) cnt++;
            if (!cont_eql) begin ok = 1; break; end
            tick();
        end
        chk("single_drop_seen", 32'(ok), 32'd1);
        chk("single_eql_len", 32'(cnt), 32'd3);
        tick();
        ackout = 1'b1;
        tick();
        ackout = 1'b0;
        chk("single_cont_back", 32'(cont_eql), 32'd1);
        chk("single_ack_early", 32'(ack), 32'd0);
        tick();
        chk("single_ack", 32'(ack), 32'b0100);
        chk("model_ptr_after_single", 32'(m_ptr), 32'd3);
        req = 4'b1111; hold_len = 4'd1; ackout = 1'b1;
        tick();
        chk("single_ack_pulse", 32'(ack), 32'd0);
        chk("ptr3_grant", 32'(grant), 32'b1000);

        // Round robin with all requesters active.
        prev = grant; n_got = 0;
        for (int i = 0; i < 80 && n_got < 5; i++) begin
            tick();
            if (grant != 0 && prev == 0) begin
                chk($sformatf("rr_order_%0d", n_got), 32'(grant), 32'(order[n_got]));
                n_got++;
            end
            prev = grant;
        end
        chk("rr_count", 32'(n_got), 32'd5);

        // Timeout with the handler never acknowledging.
        req = '0;
        wait_grant_clear("rr_drain");
        req = 4'b0010; ackout = 1'b0;
        tick();
        chk("tmo_grant", 32'(grant), 32'b0010);
        req = '0;
        cnt = 0; ok = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (timeout) begin ok = 1; break; end
            if (!cont_eql) cnt++;
        end
        chk("tmo_seen", 32'(ok), 32'd1);
        chk("tmo_drop_cycles", 32'(cnt), 32'd15);
        chk("tmo_no_ack", 32'(ack), 32'd0);
        tick();
        chk("tmo_grant_clear", 32'(grant), 32'd0);
        chk("tmo_ack_still_0", 32'(ack), 32'd0);
        chk("model_ptr_after_tmo", 32'(m_ptr), 32'd2);

        // Zero hold length, granted from pointer 2.
        req = 4'b1111; hold_len = 4'd0;
        tick();
        chk("hl0_grant", 32'(grant), 32'b0100);
        cnt = 0;
        for (int i = 0; i < 10 && cont_eql; i++) begin
            if (eql) cnt++;
            tick();
        end
        chk("hl0_eql_len", 32'(cnt), 32'd1);
        req = '0; ackout = 1'b1;
        wait_grant_clear("hl0_done");
        ackout = 1'b0;

        // busy_cnt saturation, then reset while waiting on the handler.
        req = 4'b0001; hold_len = 4'd15; enable_count = 1'b1;
        tick();
        req = '0;
        repeat (20) tick();
        chk("busy_sat", 32'(busy_cnt), 32'd15);
        chk("model_busy_sat", 32'(e_busy), 32'd15);
        chk("busy_in_drop", 32'(cont_eql), 32'd0);
        enable_count = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrst_outputs", 32'({eql, cont_eql, grant, ack}), 32'({1'b0, 1'b1, 4'b0, 4'b0}));
        chk("model_ptr_after_rst", 32'(m_ptr), 32'd0);
        req = 4'b1111; hold_len = 4'd2;
        tick();
        chk("midrst_regrant", 32'(grant), 32'b0001);

        // Random traffic, including handler stalls and occasional reset.
        ack_pct = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 256 == 0) ack_pct = int'($urandom_range(0, 100));
            reset = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 9) < 3) req = '0;
            else req = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) hold_len = CNT_W'($urandom_range(0, 5));
            ackout = (int'($urandom_range(0, 99)) < ack_pct);
            enable_count = 1'($urandom_range(0, 1));
            tick();
        end
        reset = 1'b1; req = '0; ackout = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
